prog_ram_loader: RTL and testbench
==================================

PROG_RAM_LOADER -- requirements
Module: prog_ram_loader

Interface
REQ-001 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port ld_data, input, 8: host program byte.
REQ-004 SHALL have port ld_valid, input, 1: ld_data valid; a byte transfers on a clk edge where ld_valid=1 and ld_ready=1.
REQ-005 SHALL have port ld_ready, output, 1: loader can accept a byte.
REQ-006 SHALL have port address, input, 5: CPU fetch/read address.
REQ-007 SHALL have port data_out, output, 8: program byte at address.
REQ-008 SHALL have port cpu_hold, output, 1: keep CPU in reset while 1.
REQ-009 SHALL have port load_done, output, 1: last load committed successfully.
REQ-010 SHALL have port load_err, output, 1: last load aborted.

Function
REQ-011 SHALL hold a 32x8 program RAM; data_out = RAM[address], combinational, zero latency, valid in every state.
REQ-012 SHALL run the FSM IDLE, LEN, DATA, CSUM, COMMIT, DONE, ERR; each transition consumes exactly one transferred byte unless stated otherwise.
REQ-013 In IDLE, DONE and ERR, header byte 0xA5 -> LEN, clears load_done/load_err, sets cpu_hold=1; any other byte is dropped with no state change.
REQ-014 In LEN, byte N with 1<=N<=32 latches length, clears byte index and running sum -> DATA; N=0 or N>32 -> ERR.
REQ-015 In DATA, each byte SHALL be written to RAM[index] on the transfer edge, index+=1, sum = (sum+byte) mod 256; after the Nth byte -> CSUM.
REQ-016 In CSUM, byte equal to sum -> COMMIT; otherwise -> ERR.
REQ-017 COMMIT SHALL last exactly one cycle with ld_ready=0, then -> DONE with load_done=1 and cpu_hold=0 the following cycle.
REQ-018 ld_ready SHALL be 1 in every state except COMMIT.
REQ-019 In ERR, load_err=1 and cpu_hold stays 1; RAM keeps the partially written bytes; exit only via a new header.
REQ-020 RAM bytes at index >= N SHALL keep their previous contents.
REQ-021 ld_valid=0 cycles inside a load SHALL stall without timeout and without changing state.
REQ-022 A 0xA5 inside LEN/DATA/CSUM SHALL be treated as payload, not as a restart.

Reset
REQ-023 With rst=1 at a clk edge: state=IDLE, all 32 RAM bytes=0x00 (NOP), index=0, sum=0, cpu_hold=0, load_done=0, load_err=0, ld_ready=1 the cycle after.
REQ-024 rst during any load state SHALL abort it and take precedence over a simultaneous byte transfer; that byte is not written.

Configuration
REQ-025 With LOADER_CHECKSUM_EN defined, CSUM and REQ-016 SHALL be present.
REQ-026 Without LOADER_CHECKSUM_EN, CSUM SHALL be omitted; DATA after the Nth byte -> COMMIT directly, and no checksum byte is expected.

Structure
REQ-027 Shared package SHALL hold: FSM state encoding, header constant 0xA5, RAM depth 32, address width 5.
REQ-028 A sub-module prog_ram_32B SHALL implement the RAM: synchronous write port (we, waddr, wdata), combinational read port, synchronous clear on rst.

Verification
REQ-029 Reset then read all addresses -> data_out=0x00 everywhere, cpu_hold=0, ld_ready=1.
REQ-030 Send A5,03,01,00,05,06 (checksum on) -> RAM[0..2]=01,00,05, COMMIT cycle shows ld_ready=0, then load_done=1, cpu_hold=0; RAM[3]=00.
REQ-031 Send A5,02,11,22,00 -> checksum mismatch (expected 33) -> load_err=1, cpu_hold=1, RAM[0..1]=11,22; then A5,01,7F,7F -> load_done=1.
REQ-032 Send A5,00 and A5,21 -> load_err=1 after each, RAM unchanged.
REQ-033 Send A5,04,AA,A5 with ld_valid gaps, assert rst with next byte valid -> state IDLE, RAM all 0x00, cpu_hold=0.
REQ-034 Build without LOADER_CHECKSUM_EN, send A5,02,1B,00 -> load_done=1 right after COMMIT, RAM[0..1]=1B,00.

Source files
------------

// File: rtl/prog_ram_loader_pkg.sv
// Shared definitions for the program RAM loader: FSM encoding, header byte and RAM geometry.
package prog_ram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN    = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam int         RAM_DEPTH = 32;
    localparam int         ADDR_W    = 5;
    localparam int         LEN_W     = 6;

    // A length byte is usable only if it names 1..RAM_DEPTH bytes.
    function automatic logic len_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= 8'(RAM_DEPTH));
    endfunction

endpackage

// File: rtl/prog_ram_32B.sv
// 32x8 program RAM: one synchronous write port, combinational read, cleared to 0x00 (NOP) on rst.
module prog_ram_32B
    import prog_ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_ram_loader.sv
// Host-to-program-RAM loader holding the CPU in reset while a framed image is written.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte after the payload.
//
//   state  | meaning
//   IDLE   | after reset, waiting for header 0xA5
//   LEN    | next byte is payload length N (1..32)
//   DATA   | writing payload bytes to RAM[0..N-1]
//   CSUM   | next byte must equal payload sum (checksum build only)
//   COMMIT | one cycle, no byte accepted, releases CPU next
//   DONE   | load committed, CPU running, header restarts
//   ERR    | load aborted, CPU held, header restarts
module prog_ram_loader
    import prog_ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] address,
    output logic [7:0]        data_out,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              xfer;
    logic              ram_we;

    assign xfer = ld_valid & ready_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        ram_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (xfer && ld_data == HDR_BYTE) begin
                    state_d = ST_LEN;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if (len_ok(ld_data)) begin
                        len_d   = ld_data[LEN_W-1:0];
                        idx_d   = '0;
                        sum_d   = 8'h00;
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    ram_we = 1'b1;
                    idx_d  = idx_q + 6'd1;
                    sum_d  = sum_q + ld_data;
                    if (idx_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_COMMIT;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    if (ld_data == sum_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                hold_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d != ST_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= 8'h00;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    prog_ram_32B u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (idx_q[ADDR_W-1:0]),
        .wdata (ld_data),
        .raddr (address),
        .rdata (data_out)
    );

    assign ld_ready  = ready_q;
    assign cpu_hold  = hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_prog_ram_loader.sv
// Directed bench for prog_ram_loader; follows LOADER_CHECKSUM_EN to pick the framing it sends.
module tb_prog_ram_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ld_data;
    logic       ld_valid;
    logic       ld_ready;
    logic [4:0] address;
    logic [7:0] data_out;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    int n_checks = 0;
    int n_fail   = 0;

    prog_ram_loader dut (
        .clk       (clk),
        .rst       (rst),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .address   (address),
        .data_out  (data_out),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] bytes;     // first byte sent in bits 47:40
        int          nb;
        logic        commit;    // load ends in COMMIT/DONE, else ERR
        logic [31:0] exp_ram;   // RAM[0..3], RAM[0] in bits 31:24
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        address = 5'(a);
        #1;
        d = data_out;
    endtask

    task automatic chk_ram(input string name, input int a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        chk($sformatf("%s ram[%0d]", name, a), 32'(d), 32'(exp));
    endtask

    // Present a byte, wait (bounded) for ld_ready, return just after the transfer edge.
    task automatic send(input logic [7:0] b);
        int guard;
        ld_data  = b;
        ld_valid = 1'b1;
        guard    = 0;
        while (!ld_ready && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard == 10) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: ld_ready stuck at 0 for byte %0h", b);
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [47:0] bv;
        logic [7:0]  b;
        logic [7:0]  sum;
        string       nm;

        rst      = 1'b1;
        ld_data  = 8'h00;
        ld_valid = 1'b0;
        address  = 5'd0;

`ifdef LOADER_CHECKSUM_EN
        vecs[0] = '{48'hA5_03_01_00_05_06, 6, 1'b1, 32'h01_00_05_00};
        vecs[1] = '{48'hA5_02_11_22_00_00, 5, 1'b0, 32'h11_22_05_00};
        vecs[2] = '{48'hA5_01_7F_7F_00_00, 4, 1'b1, 32'h7F_22_05_00};
        vecs[3] = '{48'hA5_00_00_00_00_00, 2, 1'b0, 32'h7F_22_05_00};
        vecs[4] = '{48'hA5_21_00_00_00_00, 2, 1'b0, 32'h7F_22_05_00};
        vecs[5] = '{48'h33_A5_02_A5_11_B6, 6, 1'b1, 32'hA5_11_05_00};
`else
        vecs[0] = '{48'hA5_02_1B_00_00_00, 4, 1'b1, 32'h1B_00_00_00};
        vecs[1] = '{48'hA5_03_01_00_05_00, 5, 1'b1, 32'h01_00_05_00};
        vecs[2] = '{48'hA5_00_00_00_00_00, 2, 1'b0, 32'h01_00_05_00};
        vecs[3] = '{48'hA5_21_00_00_00_00, 2, 1'b0, 32'h01_00_05_00};
        vecs[4] = '{48'h33_A5_01_7F_00_00, 4, 1'b1, 32'h7F_00_05_00};
        vecs[5] = '{48'hA5_02_A5_11_00_00, 4, 1'b1, 32'hA5_11_05_00};
`endif

        idle_cycles(2);
        rst = 1'b0;
        #1;

        chk("reset cpu_hold", 32'(cpu_hold), 32'd0);
        chk("reset ld_ready", 32'(ld_ready), 32'd1);
        chk("reset load_done", 32'(load_done), 32'd0);
        chk("reset load_err", 32'(load_err), 32'd0);
        for (int a = 0; a < 32; a++) chk_ram("reset", a, 8'h00);

        for (int v = 0; v < 6; v++) begin
            bv = vecs[v].bytes;
            for (int k = 0; k < vecs[v].nb; k++) send(bv[47-8*k -: 8]);
            nm = $sformatf("vec%0d", v);
            if (vecs[v].commit) begin
                chk({nm, " commit ld_ready"}, 32'(ld_ready), 32'd0);
                chk({nm, " commit cpu_hold"}, 32'(cpu_hold), 32'd1);
                chk({nm, " commit load_done"}, 32'(load_done), 32'd0);
                idle_cycles(1);
            end
            chk({nm, " load_done"}, 32'(load_done), 32'(vecs[v].commit));
            chk({nm, " load_err"}, 32'(load_err), 32'(!vecs[v].commit));
            chk({nm, " cpu_hold"}, 32'(cpu_hold), 32'(!vecs[v].commit));
            chk({nm, " ld_ready"}, 32'(ld_ready), 32'd1);
            bv = {16'h0, vecs[v].exp_ram};
            for (int a = 0; a < 4; a++) chk_ram(nm, a, bv[31-8*a -: 8]);
        end

        // Full 32-byte image with stalls between some bytes.
        send(8'hA5);
        send(8'h20);
        sum = 8'h00;
        for (int i = 0; i < 32; i++) begin
            b   = 8'(i * 3 + 1);
            sum = sum + b;
            if (i % 5 == 2) begin
                idle_cycles(3);
                chk($sformatf("stall%0d ld_ready", i), 32'(ld_ready), 32'd1);
                chk($sformatf("stall%0d cpu_hold", i), 32'(cpu_hold), 32'd1);
                chk($sformatf("stall%0d load_done", i), 32'(load_done), 32'd0);
            end
            send(b);
        end
`ifdef LOADER_CHECKSUM_EN
        send(sum);
`endif
        chk("full commit ld_ready", 32'(ld_ready), 32'd0);
        idle_cycles(1);
        chk("full load_done", 32'(load_done), 32'd1);
        chk("full cpu_hold", 32'(cpu_hold), 32'd0);
        for (int a = 0; a < 32; a++) chk_ram("full", a, 8'(a * 3 + 1));

        // Short load leaves bytes beyond N untouched.
        send(8'hA5);
        send(8'h02);
        send(8'hEE);
        send(8'h01);
`ifdef LOADER_CHECKSUM_EN
        send(8'hEF);
`endif
        idle_cycles(1);
        chk("short load_done", 32'(load_done), 32'd1);
        chk_ram("short", 0, 8'hEE);
        chk_ram("short", 1, 8'h01);
        chk_ram("short", 2, 8'h07);
        chk_ram("short", 31, 8'h5E);

        // Reset mid-load, colliding with a valid byte.
        send(8'hA5);
        idle_cycles(2);
        send(8'h04);
        send(8'hAA);
        idle_cycles(1);
        send(8'hA5);
        chk("midload cpu_hold", 32'(cpu_hold), 32'd1);
        ld_data  = 8'h55;
        ld_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ld_valid = 1'b0;
        chk("abort cpu_hold", 32'(cpu_hold), 32'd0);
        chk("abort ld_ready", 32'(ld_ready), 32'd1);
        chk("abort load_done", 32'(load_done), 32'd0);
        chk("abort load_err", 32'(load_err), 32'd0);
        for (int a = 0; a < 32; a++) chk_ram("abort", a, 8'h00);
        send(8'h55);
        chk("idle drop cpu_hold", 32'(cpu_hold), 32'd0);
        send(8'hA5);
        chk("idle hdr cpu_hold", 32'(cpu_hold), 32'd1);
        chk("idle hdr load_done", 32'(load_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
